// File: rtl/arb_pkg.sv
// Shared definitions for the grant arbiter family: agent count,
// owner index width and the bus-ownership state encoding.
package arb_pkg;

    localparam int NUM_AGENTS = 4;
    localparam int OWNER_W    = 2;

    typedef logic [OWNER_W-1:0] owner_t;

    // Ownership states, kept as plain constants so older code can compare against them
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OWNED   = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;
    localparam logic [1:0] ERROR   = 2'd3;

endpackage

// File: rtl/gnt_decode.sv
// Classifies a grant vector as zero, one-hot (with its index) or multi-hot.
// Purely combinational; idx is only meaningful when any=1 and multi=0.
module gnt_decode
    import arb_pkg::*;
(
    input  logic [NUM_AGENTS-1:0] gnt,
    output logic                  any,
    output logic                  multi,
    output owner_t                idx
);

    localparam logic [NUM_AGENTS-1:0] ONE = NUM_AGENTS'(1);

    // Clearing the lowest set bit leaves something only if two or more bits were set
    always_comb begin
        any   = |gnt;
        multi = |(gnt & (gnt - ONE));
        idx   = '0;
        for (int i = NUM_AGENTS - 1; i >= 0; i--) begin
            if (gnt[i]) begin
                idx = OWNER_W'(i);
            end
        end
    end

endmodule

// File: rtl/grant_bus_mux.sv
// Routes the granted agent's beat onto the shared bus, tracks bus ownership,
// caps each grant tenure at MAX_TENURE beats and flags grant-protocol
// violations (multi-hot grants, owner change without an idle cycle).
// All outputs are registered; latency is one cycle.
module grant_bus_mux
    import arb_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MAX_TENURE = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic              gnt_2,
    input  logic              gnt_3,
    input  logic              valid_0,
    input  logic              valid_1,
    input  logic              valid_2,
    input  logic              valid_3,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] data_3,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic [1:0]        bus_owner,
    output logic              bus_busy,
    output logic              tenure_expired,
    output logic              grant_error,
    output logic [15:0]       xfer_count
);

    localparam int                TEN_W   = $clog2(MAX_TENURE + 1);
    localparam logic [TEN_W-1:0]  TEN_MAX = TEN_W'(MAX_TENURE);
    localparam logic [TEN_W-1:0]  TEN_ONE = TEN_W'(1);

    logic [NUM_AGENTS-1:0] gnt_vec;
    logic [NUM_AGENTS-1:0] valid_vec;
    logic [DATA_W-1:0]     data_arr [NUM_AGENTS];

    logic   g_any;
    logic   g_multi;
    owner_t g_idx;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [TEN_W-1:0] tenure;
    logic [TEN_W-1:0] next_tenure;
    logic             fwd;
    logic             load_owner;

    assign gnt_vec   = {gnt_3, gnt_2, gnt_1, gnt_0};
    assign valid_vec = {valid_3, valid_2, valid_1, valid_0};
    assign data_arr[0] = data_0;
    assign data_arr[1] = data_1;
    assign data_arr[2] = data_2;
    assign data_arr[3] = data_3;

    gnt_decode u_gnt_decode (
        .gnt   (gnt_vec),
        .any   (g_any),
        .multi (g_multi),
        .idx   (g_idx)
    );

    // Next ownership state, tenure and whether this cycle forwards a beat.
    // Whenever a beat is forwarded, g_idx is the (new or continuing) owner.
    always_comb begin
        next_state  = state;
        next_tenure = tenure;
        fwd         = 1'b0;
        load_owner  = 1'b0;
        case (state)
            IDLE: begin
                if (g_multi) begin
                    next_state = ERROR;
                end else if (g_any) begin
                    next_state  = OWNED;
                    next_tenure = TEN_ONE;
                    load_owner  = 1'b1;
                    fwd         = valid_vec[g_idx];
                end
            end
            OWNED: begin
                if (!g_any) begin
                    next_state  = IDLE;
                    next_tenure = '0;
                end else if (g_multi || (g_idx != bus_owner)) begin
                    next_state  = ERROR;
                    next_tenure = '0;
                end else if (tenure < TEN_MAX) begin
                    next_tenure = tenure + TEN_ONE;
                    fwd         = valid_vec[g_idx];
                end else begin
                    next_state = EXPIRED;
                end
            end
            EXPIRED: begin
                if (!g_any) begin
                    next_state  = IDLE;
                    next_tenure = '0;
                end else if (g_multi || (g_idx != bus_owner)) begin
                    next_state  = ERROR;
                    next_tenure = '0;
                end
            end
            ERROR: begin
                if (!g_any) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state  = IDLE;
                next_tenure = '0;
            end
        endcase
    end

    // Register state and every output; grant_error is sticky until reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            tenure         <= '0;
            bus_valid      <= 1'b0;
            bus_data       <= '0;
            bus_owner      <= '0;
            bus_busy       <= 1'b0;
            tenure_expired <= 1'b0;
            grant_error    <= 1'b0;
            xfer_count     <= '0;
        end else begin
            state          <= next_state;
            tenure         <= next_tenure;
            bus_valid      <= fwd;
            bus_busy       <= (next_state == OWNED) || (next_state == EXPIRED);
            tenure_expired <= (next_state == EXPIRED);
            if (fwd) begin
                bus_data   <= data_arr[g_idx];
                xfer_count <= xfer_count + 16'd1;
            end
            if (load_owner) begin
                bus_owner <= g_idx;
            end
            if (next_state == ERROR) begin
                grant_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grant_bus_mux.sv
// Scoreboard bench for grant_bus_mux. The driver steps a behavioural model
// of bus ownership alongside the DUT and queues expected beats and status;
// a monitor on the falling edge pops and compares them.
module tb_grant_bus_mux;

    localparam int DATA_W     = 8;
    localparam int MAX_TENURE = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              gnt_0 = 1'b0, gnt_1 = 1'b0, gnt_2 = 1'b0, gnt_3 = 1'b0;
    logic              valid_0 = 1'b0, valid_1 = 1'b0, valid_2 = 1'b0, valid_3 = 1'b0;
    logic [DATA_W-1:0] data_0 = '0, data_1 = '0, data_2 = '0, data_3 = '0;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic [1:0]        bus_owner;
    logic              bus_busy;
    logic              tenure_expired;
    logic              grant_error;
    logic [15:0]       xfer_count;

    grant_bus_mux #(.DATA_W(DATA_W), .MAX_TENURE(MAX_TENURE)) dut (
        .clock          (clock),
        .reset          (reset),
        .gnt_0          (gnt_0),
        .gnt_1          (gnt_1),
        .gnt_2          (gnt_2),
        .gnt_3          (gnt_3),
        .valid_0        (valid_0),
        .valid_1        (valid_1),
        .valid_2        (valid_2),
        .valid_3        (valid_3),
        .data_0         (data_0),
        .data_1         (data_1),
        .data_2         (data_2),
        .data_3         (data_3),
        .bus_valid      (bus_valid),
        .bus_data       (bus_data),
        .bus_owner      (bus_owner),
        .bus_busy       (bus_busy),
        .tenure_expired (tenure_expired),
        .grant_error    (grant_error),
        .xfer_count     (xfer_count)
    );

    // Free-running clock, 10 ns period
    always #5 clock = ~clock;

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic [1:0]        own;
        logic              busy;
        logic              texp;
        logic              gerr;
        logic [15:0]       cnt;
    } status_t;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [1:0]        own;
        logic [15:0]       cnt;
    } beat_t;

    status_t statQ[$];
    beat_t   beatQ[$];

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, how many grant cycles they have used,
    // whether they overstayed, and whether we are waiting out a violation.
    int                mOwner     = -1;
    int                mUsed      = 0;
    bit                mExpired   = 1'b0;
    bit                mBroken    = 1'b0;
    bit                mSticky    = 1'b0;
    logic [DATA_W-1:0] mData      = '0;
    logic [1:0]        mLastOwner = '0;
    logic [15:0]       mCount     = '0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] g, input logic [3:0] v,
                                 input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                                 input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3);
        logic [DATA_W-1:0] dArr [4];
        int      n;
        int      idx;
        bit      fwd;
        status_t s;
        beat_t   b;
        reset = rst;
        {gnt_3, gnt_2, gnt_1, gnt_0}         = g;
        {valid_3, valid_2, valid_1, valid_0} = v;
        data_0 = d0; data_1 = d1; data_2 = d2; data_3 = d3;
        dArr[0] = d0; dArr[1] = d1; dArr[2] = d2; dArr[3] = d3;
        n   = $countones(g);
        idx = 0;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        fwd = 1'b0;
        if (rst) begin
            mOwner = -1; mUsed = 0; mExpired = 0; mBroken = 0; mSticky = 0;
            mData = '0; mLastOwner = '0; mCount = '0;
        end else if (mBroken) begin
            if (n == 0) mBroken = 0;
        end else if (mOwner < 0) begin
            if (n == 1) begin
                mOwner = idx; mLastOwner = 2'(idx); mUsed = 1; mExpired = 0;
                fwd = v[idx];
            end else if (n > 1) begin
                mBroken = 1; mSticky = 1;
            end
        end else begin
            if (n == 0) begin
                mOwner = -1; mExpired = 0;
            end else if (n == 1 && idx == mOwner) begin
                if (mUsed < MAX_TENURE) begin
                    mUsed++;
                    fwd = v[idx];
                end else begin
                    mExpired = 1;
                end
            end else begin
                mBroken = 1; mSticky = 1; mOwner = -1; mExpired = 0;
            end
        end
        if (fwd) begin
            mData  = dArr[idx];
            mCount = mCount + 16'd1;
        end
        @(posedge clock);
        s.v = fwd; s.d = mData; s.own = mLastOwner; s.busy = (mOwner >= 0);
        s.texp = mExpired; s.gerr = mSticky; s.cnt = mCount;
        statQ.push_back(s);
        if (fwd) begin
            b.d = mData; b.own = mLastOwner; b.cnt = mCount;
            beatQ.push_back(b);
        end
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic grantCycles(input int agent, input int n, input logic [3:0] v);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 4'(1 << agent), v, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Monitor: compare status every cycle and pop a beat whenever the bus presents one
    always @(negedge clock) begin
        status_t s;
        beat_t   b;
        if (statQ.size() > 0) begin
            s = statQ.pop_front();
            checkOutput("bus_valid", 32'(bus_valid), 32'(s.v));
            checkOutput("bus_data", 32'(bus_data), 32'(s.d));
            checkOutput("bus_owner", 32'(bus_owner), 32'(s.own));
            checkOutput("bus_busy", 32'(bus_busy), 32'(s.busy));
            checkOutput("tenure_expired", 32'(tenure_expired), 32'(s.texp));
            checkOutput("grant_error", 32'(grant_error), 32'(s.gerr));
            checkOutput("xfer_count", 32'(xfer_count), 32'(s.cnt));
            if (bus_valid === 1'b1) begin
                if (beatQ.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(bus_data), 32'hFFFF_FFFF);
                end else begin
                    b = beatQ.pop_front();
                    checkOutput("beat_data", 32'(bus_data), 32'(b.d));
                    checkOutput("beat_owner", 32'(bus_owner), 32'(b.own));
                    checkOutput("beat_count", 32'(xfer_count), 32'(b.cnt));
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, a randomized stretch, then the counter wrap
    initial begin
        logic [3:0] g;
        @(negedge clock);
        applyStimulus(1, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus(1, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        idleCycles(1);

        $display("[TB] agent 1 three-beat transfer");
        applyStimulus(0, 4'h2, 4'hF, 8'hA0, 8'h11, 8'hB0, 8'hC0);
        applyStimulus(0, 4'h2, 4'hF, 8'hA1, 8'h22, 8'hB1, 8'hC1);
        applyStimulus(0, 4'h2, 4'hF, 8'hA2, 8'h33, 8'hB2, 8'hC2);
        idleCycles(2);

        $display("[TB] tenure expiry on agent 2");
        grantCycles(2, MAX_TENURE + 4, 4'hF);
        idleCycles(2);

        $display("[TB] multi-hot grant then clean transfer");
        applyStimulus(0, 4'h9, 4'hF, 8'h01, 8'h02, 8'h03, 8'h04);
        idleCycles(1);
        grantCycles(1, 3, 4'hF);
        idleCycles(1);

        $display("[TB] owner switch without idle");
        grantCycles(0, 2, 4'hF);
        grantCycles(2, 3, 4'hF);
        idleCycles(1);
        grantCycles(2, 2, 4'hF);
        idleCycles(1);

        $display("[TB] reset mid-grant");
        grantCycles(1, 3, 4'hF);
        applyStimulus(1, 4'h2, 4'hF, 8'h55, 8'h66, 8'h77, 8'h88);
        grantCycles(1, 2, 4'hF);
        idleCycles(1);

        $display("[TB] randomized grants");
        g = 4'h0;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    g = 4'h0;
                2, 3:    g = 4'(1 << $urandom_range(0, 3));
                4:       g = 4'($urandom);
                default: g = g;
            endcase
            applyStimulus(0, g, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        idleCycles(2);

        $display("[TB] xfer_count wrap");
        applyStimulus(1, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int blk = 0; blk < 65536 / MAX_TENURE; blk++) begin
            grantCycles($urandom_range(0, 3), MAX_TENURE, 4'hF);
            idleCycles(1);
        end
        grantCycles(3, 1, 4'hF);
        idleCycles(2);

        @(negedge clock);
        #1;
        checkOutput("queues_drained", 32'(statQ.size() + beatQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
